stress_seq_checker: RTL and testbench

Serial-stream checker at the receiving end of the fabric stress chain. Consumes the single-bit stress output together with a qualifying strobe, self-synchronises to the XOR-recurrence sequence, and then counts every bit that deviates from the predicted value. It sits between the stress chain's output and the status/debug logic, so a long soak run can report lock status and a cumulative error count instead of a bare toggling pin.

---
 rtl/stress_pkg.sv | 13 +
 rtl/stress_seq_hist.sv | 27 ++
 rtl/stress_seq_checker.sv | 131 +++++++++++++
 tb/tb_stress_seq_checker.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stress_pkg.sv
// rtl/stress_pkg.sv - shared types and defaults for the fabric stress generator/checker pair
package stress_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } stress_state_e;

    localparam int STRESS_DEFAULT_WIDTH = 4;
    localparam logic [STRESS_DEFAULT_WIDTH-1:0] STRESS_DEFAULT_TAPS = 4'b1111;

endpackage

// File: rtl/stress_seq_hist.sv
// rtl/stress_seq_hist.sv - received-bit history shift register and next-bit prediction
module stress_seq_hist
    import stress_pkg::*;
#(
    parameter int              WIDTH = STRESS_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = STRESS_DEFAULT_TAPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             in_bit,
    output logic [WIDTH-1:0] hist,
    output logic             p
);

    // Received bit (not the prediction) enters history, so the checker resyncs on its own
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (shift_en) begin
            hist <= {hist[WIDTH-2:0], in_bit};
        end
    end

    assign p = ^(hist & TAPS);

endmodule

// File: rtl/stress_seq_checker.sv
// rtl/stress_seq_checker.sv - self-synchronising XOR-recurrence stream checker with lock and error count
module stress_seq_checker
    import stress_pkg::*;
#(
    parameter int               WIDTH      = STRESS_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = STRESS_DEFAULT_TAPS,
    parameter int               LOCK_COUNT = 16,
    parameter int               ERR_LIMIT  = 8,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             clr,
    output logic             locked,
    output logic             lost_lock,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] S_FILL   = ST_FILL;
    localparam logic [1:0] S_TRAIN  = ST_TRAIN;
    localparam logic [1:0] S_LOCKED = ST_LOCKED;

    localparam logic [4:0] FILL_LAST = 5'(WIDTH - 1);
    localparam logic [7:0] GOOD_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [7:0] MISS_LAST = 8'(ERR_LIMIT - 1);

    logic [1:0]       state;
    logic [4:0]       fill_cnt;
    logic [7:0]       good_cnt;
    logic [7:0]       miss_cnt;
    logic [WIDTH-1:0] hist;
    logic             p;
    logic             mismatch;
    logic             hist_nz;
    logic             count_err;
    logic             lose_lock;

    stress_seq_hist #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_hist (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (in_valid),
        .in_bit   (in_bit),
        .hist     (hist),
        .p        (p)
    );

    assign mismatch  = in_valid && (in_bit != p);
    assign hist_nz   = |hist;
    assign count_err = (state == S_LOCKED) && mismatch;
    assign lose_lock = count_err && (miss_cnt == MISS_LAST);
    assign locked    = (state == S_LOCKED);

    // Fill / train / locked sequencing, advanced only on valid samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_FILL;
            fill_cnt <= '0;
            good_cnt <= '0;
            miss_cnt <= '0;
        end else if (in_valid) begin
            case (state)
                S_FILL: begin
                    if (fill_cnt == FILL_LAST) begin
                        state    <= S_TRAIN;
                        fill_cnt <= '0;
                        good_cnt <= '0;
                    end else begin
                        fill_cnt <= fill_cnt + 5'd1;
                    end
                end
                S_TRAIN: begin
                    // An all-zero history trivially predicts zero, so it never earns credit
                    if (!mismatch && hist_nz) begin
                        if (good_cnt == GOOD_LAST) begin
                            state    <= S_LOCKED;
                            good_cnt <= '0;
                            miss_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + 8'd1;
                        end
                    end else begin
                        good_cnt <= '0;
                    end
                end
                S_LOCKED: begin
                    if (mismatch) begin
                        if (miss_cnt == MISS_LAST) begin
                            state    <= S_FILL;
                            fill_cnt <= '0;
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + 8'd1;
                        end
                    end else begin
                        miss_cnt <= '0;
                    end
                end
                default: begin
                    state    <= S_FILL;
                    fill_cnt <= '0;
                    good_cnt <= '0;
                    miss_cnt <= '0;
                end
            endcase
        end
    end

    // Status: clr beats a counted error, but a loss of lock in the same cycle still sticks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
            lost_lock <= 1'b0;
        end else if (clr) begin
            err_count <= '0;
            lost_lock <= lose_lock;
        end else begin
            if (count_err && (err_count != {CNT_W{1'b1}})) begin
                err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (lose_lock) begin
                lost_lock <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stress_seq_checker.sv
// tb/tb_stress_seq_checker.sv - randomized self-checking bench for stress_seq_checker
module tb_stress_seq_checker;

    localparam int         WIDTH      = 4;
    localparam logic [3:0] TAPS       = 4'b1111;
    localparam int         LOCK_COUNT = 16;
    localparam int         ERR_LIMIT  = 8;
    localparam int         M_FILL     = 0;
    localparam int         M_TRAIN    = 1;
    localparam int         M_LOCKED   = 2;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_bit   = 1'b0;
    logic        in_valid = 1'b0;
    logic        clr      = 1'b0;
    logic        locked, lost_lock;
    logic [15:0] err_count;
    logic        locked_s, lost_lock_s;
    logic [3:0]  err_count_s;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    stress_seq_checker #(
        .WIDTH(WIDTH), .TAPS(TAPS), .LOCK_COUNT(LOCK_COUNT), .ERR_LIMIT(ERR_LIMIT), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .clr(clr),
        .locked(locked), .lost_lock(lost_lock), .err_count(err_count)
    );

    stress_seq_checker #(
        .WIDTH(WIDTH), .TAPS(TAPS), .LOCK_COUNT(LOCK_COUNT), .ERR_LIMIT(ERR_LIMIT), .CNT_W(4)
    ) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .clr(clr),
        .locked(locked_s), .lost_lock(lost_lock_s), .err_count(err_count_s)
    );

    // Reference model: history as a queue (newest first), phases and counts as plain ints
    bit m_hist[$];
    int m_phase, m_fill, m_good, m_miss, m_err;
    bit m_lost;
    int pat_idx = 0;
    bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    function automatic void model_reset();
        m_hist.delete();
        for (int k = 0; k < WIDTH; k++) m_hist.push_back(1'b0);
        m_phase = M_FILL;
        m_fill  = 0;
        m_good  = 0;
        m_miss  = 0;
        m_err   = 0;
        m_lost  = 1'b0;
    endfunction

    function automatic bit model_pred();
        bit pr = 1'b0;
        for (int k = 0; k < WIDTH; k++) if (TAPS[k]) pr ^= m_hist[k];
        return pr;
    endfunction

    function automatic void model_step(bit b, bit v, bit c);
        bit lose   = 1'b0;
        bit any1   = 1'b0;
        bit miss;
        if (v) begin
            miss = (b != model_pred());
            foreach (m_hist[k]) any1 |= m_hist[k];
            if (m_phase == M_FILL) begin
                m_fill++;
                if (m_fill == WIDTH) begin
                    m_phase = M_TRAIN;
                    m_good  = 0;
                end
            end else if (m_phase == M_TRAIN) begin
                if (!miss && any1) begin
                    m_good++;
                    if (m_good == LOCK_COUNT) begin
                        m_phase = M_LOCKED;
                        m_miss  = 0;
                    end
                end else begin
                    m_good = 0;
                end
            end else begin
                if (miss) begin
                    m_err++;
                    m_miss++;
                    if (m_miss == ERR_LIMIT) begin
                        lose    = 1'b1;
                        m_phase = M_FILL;
                        m_fill  = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
            m_hist.push_front(b);
            void'(m_hist.pop_back());
        end
        if (c) begin
            m_err  = 0;
            m_lost = lose;
        end else if (lose) begin
            m_lost = 1'b1;
        end
    endfunction

    function automatic int exp_err(int w);
        int cap = (1 << w) - 1;
        return (m_err > cap) ? cap : m_err;
    endfunction

    function automatic bit next_clean();
        bit b = pat[pat_idx % 5];
        pat_idx++;
        return b;
    endfunction

    task automatic step(input bit b, input bit v, input bit c);
        in_bit   = b;
        in_valid = v;
        clr      = c;
        @(posedge clk);
        model_step(b, v, c);
        #1;
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clr      = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (locked !== 1'b0) $display("FAIL reset_locked got %0b want 0", locked); else passed++;
        checks++; if (lost_lock !== 1'b0) $display("FAIL reset_lost got %0b want 0", lost_lock); else passed++;
        checks++; if (err_count !== 16'd0) $display("FAIL reset_err got %0d want 0", err_count); else passed++;
        checks++; if (err_count_s !== 4'd0) $display("FAIL reset_err_sat got %0d want 0", err_count_s); else passed++;
    endtask

    task automatic test_lock();
        do_reset();
        pat_idx = 0;
        for (int i = 1; i <= 1000; i++) begin
            step(next_clean(), 1'b1, 1'b0);
            checks++;
            if (locked !== (i >= WIDTH + LOCK_COUNT))
                $display("FAIL lock_time sample %0d got %0b want %0b", i, locked, (i >= WIDTH + LOCK_COUNT));
            else passed++;
            checks++;
            if (err_count !== 16'd0) $display("FAIL lock_err sample %0d got %0d want 0", i, err_count); else passed++;
        end
    endtask

    task automatic test_single_error();
        bit b;
        int gap;
        for (int r = 0; r < 4; r++) begin
            b = next_clean();
            step(~b, 1'b1, 1'b0);
            gap = $urandom_range(10, 30);
            for (int i = 0; i < gap; i++) begin
                step(next_clean(), 1'b1, 1'b0);
                checks++;
                if (err_count !== 16'(exp_err(16)))
                    $display("FAIL single_model got %0d want %0d", err_count, exp_err(16));
                else passed++;
            end
            checks++;
            if (err_count !== 16'(5 * (r + 1))) $display("FAIL single_err got %0d want %0d", err_count, 5 * (r + 1)); else passed++;
        end
        checks++; if (locked !== 1'b1) $display("FAIL single_locked got %0b want 1", locked); else passed++;
        checks++; if (lost_lock !== 1'b0) $display("FAIL single_lost got %0b want 0", lost_lock); else passed++;
    endtask

    task automatic test_lose_lock();
        step(next_clean(), 1'b1, 1'b1);
        for (int i = 0; i < ERR_LIMIT; i++) step(~model_pred(), 1'b1, 1'b0);
        checks++; if (err_count !== 16'd8) $display("FAIL lose_err got %0d want 8", err_count); else passed++;
        checks++; if (locked !== 1'b0) $display("FAIL lose_locked got %0b want 0", locked); else passed++;
        checks++; if (lost_lock !== 1'b1) $display("FAIL lose_lost got %0b want 1", lost_lock); else passed++;
        checks++; if (err_count_s !== 4'd8) $display("FAIL lose_err_sat got %0d want 8", err_count_s); else passed++;
        for (int i = 1; i <= 30; i++) begin
            step(next_clean(), 1'b1, 1'b0);
            checks++;
            if (locked !== (i >= WIDTH + LOCK_COUNT))
                $display("FAIL relock sample %0d got %0b want %0b", i, locked, (i >= WIDTH + LOCK_COUNT));
            else passed++;
        end
        checks++; if (lost_lock !== 1'b1) $display("FAIL relock_lost got %0b want 1", lost_lock); else passed++;
    endtask

    task automatic test_clr();
        bit b;
        step(next_clean(), 1'b1, 1'b1);
        checks++; if (lost_lock !== 1'b0) $display("FAIL clr_lost got %0b want 0", lost_lock); else passed++;
        checks++; if (err_count !== 16'd0) $display("FAIL clr_err got %0d want 0", err_count); else passed++;
        b = next_clean();
        step(~b, 1'b1, 1'b1);
        checks++; if (err_count !== 16'd0) $display("FAIL clr_vs_miss got %0d want 0", err_count); else passed++;
        for (int i = 0; i < 4; i++) step(next_clean(), 1'b1, 1'b0);
        checks++; if (err_count !== 16'd4) $display("FAIL clr_after got %0d want 4", err_count); else passed++;
        for (int i = 0; i < 6; i++) step(next_clean(), 1'b1, 1'b0);
        for (int i = 0; i < ERR_LIMIT - 1; i++) step(~model_pred(), 1'b1, 1'b0);
        step(~model_pred(), 1'b1, 1'b1);
        checks++; if (lost_lock !== 1'b1) $display("FAIL clr_vs_loss_lost got %0b want 1", lost_lock); else passed++;
        checks++; if (err_count !== 16'd0) $display("FAIL clr_vs_loss_err got %0d want 0", err_count); else passed++;
        checks++; if (locked !== 1'b0) $display("FAIL clr_vs_loss_locked got %0b want 0", locked); else passed++;
    endtask

    task automatic test_zeros();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            step(1'b0, 1'b1, 1'b0);
            checks++; if (locked !== 1'b0) $display("FAIL zeros_locked sample %0d got %0b want 0", i, locked); else passed++;
        end
    endtask

    task automatic test_valid_toggle();
        int nvalid = 0;
        do_reset();
        for (int c = 1; c <= 60; c++) begin
            if (c % 2 == 0) begin
                step(next_clean(), 1'b1, 1'b0);
                nvalid++;
            end else begin
                step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
            checks++;
            if (locked !== (nvalid >= WIDTH + LOCK_COUNT))
                $display("FAIL toggle_lock cycle %0d got %0b want %0b", c, locked, (nvalid >= WIDTH + LOCK_COUNT));
            else passed++;
        end
        checks++; if (locked !== 1'b1) $display("FAIL toggle_40 got %0b want 1", locked); else passed++;
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < WIDTH + LOCK_COUNT; i++) step(next_clean(), 1'b1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            step(~next_clean(), 1'b1, 1'b0);
            for (int i = 0; i < 9; i++) step(next_clean(), 1'b1, 1'b0);
        end
        checks++; if (err_count_s !== 4'd15) $display("FAIL sat_hold got %0d want 15", err_count_s); else passed++;
        checks++; if (err_count !== 16'd20) $display("FAIL sat_wide got %0d want 20", err_count); else passed++;
        checks++; if (locked_s !== 1'b1) $display("FAIL sat_locked got %0b want 1", locked_s); else passed++;
    endtask

    task automatic test_reset_mid_lock();
        in_bit   = 1'b1;
        in_valid = 1'b1;
        rst_n    = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        checks++; if (locked !== 1'b0) $display("FAIL midrst_locked got %0b want 0", locked); else passed++;
        checks++; if (lost_lock !== 1'b0) $display("FAIL midrst_lost got %0b want 0", lost_lock); else passed++;
        checks++; if (err_count !== 16'd0) $display("FAIL midrst_err got %0d want 0", err_count); else passed++;
        checks++; if (err_count_s !== 4'd0) $display("FAIL midrst_err_sat got %0d want 0", err_count_s); else passed++;
        for (int i = 1; i <= WIDTH + LOCK_COUNT; i++) begin
            step(next_clean(), 1'b1, 1'b0);
            checks++;
            if (locked !== (i == WIDTH + LOCK_COUNT))
                $display("FAIL midrst_relock sample %0d got %0b want %0b", i, locked, (i == WIDTH + LOCK_COUNT));
            else passed++;
        end
    endtask

    task automatic test_random();
        int burst = 0;
        bit b, v, c;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 199) == 0);
            if (burst > 0 && v) begin
                b = ~model_pred();
                burst--;
            end else if (v) begin
                b = next_clean();
                if ($urandom_range(0, 59) == 0) b = ~b;
                if ($urandom_range(0, 399) == 0) burst = $urandom_range(6, 9);
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            step(b, v, c);
            checks++;
            if (locked !== (m_phase == M_LOCKED))
                $display("FAIL rand_locked cyc %0d got %0b want %0b", cyc, locked, (m_phase == M_LOCKED));
            else passed++;
            checks++;
            if (lost_lock !== m_lost) $display("FAIL rand_lost cyc %0d got %0b want %0b", cyc, lost_lock, m_lost); else passed++;
            checks++;
            if (err_count !== 16'(exp_err(16))) $display("FAIL rand_err cyc %0d got %0d want %0d", cyc, err_count, exp_err(16)); else passed++;
            checks++;
            if (err_count_s !== 4'(exp_err(4))) $display("FAIL rand_err_sat cyc %0d got %0d want %0d", cyc, err_count_s, exp_err(4)); else passed++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_single_error();
        test_lose_lock();
        test_clr();
        test_zeros();
        test_valid_toggle();
        test_saturate();
        test_reset_mid_lock();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
